// File: rtl/hb_decim_stream.sv
// hb_decim_stream: half-band decimate-by-2 FIR with valid/ready streaming.
// Symmetric pre-add halves the multiplier count; the centre tap has its own
// coefficient. Two-stage pipeline (products, then accumulate/round/saturate).
// Optional feature macro: HB_SAT_CNT_EN adds a sticky saturation counter port.
module hb_decim_stream #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int NTAPS  = 27
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic signed [DATA_W-1:0]               in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic signed [DATA_W-1:0]               out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  input  logic                                   coef_wr_en,
  input  logic [$clog2((NTAPS+1)/4+1)-1:0]       coef_wr_addr,
  input  logic signed [COEF_W-1:0]               coef_wr_data
`ifdef HB_SAT_CNT_EN
  ,
  output logic [15:0]                            sat_count
`endif
);

  localparam int NUNIQ  = (NTAPS + 1) / 4;
  localparam int CTR    = (NTAPS - 1) / 2;
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = PRE_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(NUNIQ + 1) + 1;

  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(64'd1 << (COEF_W - 2));
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] taps [NTAPS];
  logic signed [COEF_W-1:0] coef [NUNIQ];
  logic signed [COEF_W-1:0] coef_c;
  logic                     phase;
  logic                     v1;
  logic                     v2;
  logic                     en;

  logic signed [PRE_W-1:0]  pre_sum  [NUNIQ];
  logic signed [PROD_W-1:0] prod_nxt [NUNIQ+1];
  logic signed [PROD_W-1:0] prod     [NUNIQ+1];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] y;
  logic                     sat_hi;
  logic                     sat_lo;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Stage-1 combinational: symmetric pre-add and full-precision products.
  always_comb begin
    for (int i = 0; i < NUNIQ; i++) begin
      pre_sum[i]  = PRE_W'(taps[2*i]) + PRE_W'(taps[NTAPS-1-2*i]);
      prod_nxt[i] = PROD_W'(pre_sum[i]) * PROD_W'(coef[i]);
    end
    prod_nxt[NUNIQ] = PROD_W'(taps[CTR]) * PROD_W'(coef_c);
  end

  // Stage-2 combinational: accumulate, round half-up, rescale and clip.
  always_comb begin
    acc = RND;
    for (int i = 0; i <= NUNIQ; i++) begin
      acc = acc + ACC_W'(prod[i]);
    end
    shifted = acc >>> (COEF_W - 1);
    sat_hi  = shifted > MAXV;
    sat_lo  = shifted < MINV;
    if (sat_hi)      y = MAXV[DATA_W-1:0];
    else if (sat_lo) y = MINV[DATA_W-1:0];
    else             y = shifted[DATA_W-1:0];
  end

  // Coefficient bank: centre defaults to one half so the filter passes x/2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUNIQ; i++) coef[i] <= '0;
      coef_c <= {2'b01, {(COEF_W-2){1'b0}}};
    end else if (coef_wr_en) begin
      if (int'(coef_wr_addr) < NUNIQ)       coef[coef_wr_addr] <= coef_wr_data;
      else if (int'(coef_wr_addr) == NUNIQ) coef_c <= coef_wr_data;
    end
  end

  // Delay line, phase and pipeline; every stage holds while the output is blocked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) taps[i] <= '0;
      for (int i = 0; i <= NUNIQ; i++) prod[i] <= '0;
      phase     <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      for (int i = 0; i < NTAPS; i++) taps[i] <= '0;
      phase     <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      if (in_valid) begin
        for (int i = NTAPS - 1; i > 0; i--) taps[i] <= taps[i-1];
        taps[0] <= in_data;
        phase   <= ~phase;
      end
      v1 <= in_valid & phase;
      if (v1) begin
        for (int i = 0; i <= NUNIQ; i++) prod[i] <= prod_nxt[i];
      end
      v2 <= v1;
      if (v2) out_data <= y;
      out_valid <= v2;
    end
  end

`ifdef HB_SAT_CNT_EN
  // Count clipped results as they load into out_data; sticks at full scale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_count <= '0;
    end else if (flush) begin
      sat_count <= '0;
    end else if (en && v2 && (sat_hi || sat_lo) && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hb_decim_stream.sv
// Bench for hb_decim_stream: convolution model over accepted samples with an
// expected-output queue, plus literal expectations for the directed tests.
module tb_hb_decim_stream;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               flush = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               coef_wr_en = 1'b0;
  logic [2:0]         coef_wr_addr = '0;
  logic signed [15:0] coef_wr_data = '0;
`ifdef HB_SAT_CNT_EN
  logic [15:0]        sat_count;
`endif

  hb_decim_stream dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data)
`ifdef HB_SAT_CNT_EN
    , .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model state: coefficients, sample history, expected outputs.
  int     m_coef [8];
  longint hist [27];
  bit     ph;
  int     exp_q [$];
  int     got [$];
  int     m_sat;
  bit     prev_stall;
  int     prev_data;

  function automatic void model_clear();
    for (int j = 0; j < 27; j++) hist[j] = 0;
    ph = 0;
    exp_q.delete();
    m_sat = 0;
    prev_stall = 0;
  endfunction

  function automatic void model_accept(int x);
    longint h [27];
    longint s;
    longint r;
    for (int j = 26; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = x;
    if (ph) begin
      for (int j = 0; j < 27; j++) h[j] = 0;
      for (int i = 0; i < 7; i++) begin
        h[2*i]      = m_coef[i];
        h[26 - 2*i] = m_coef[i];
      end
      h[13] = m_coef[7];
      s = 0;
      for (int j = 0; j < 27; j++) s += h[j] * hist[j];
      r = (s + 16384) >>> 15;
      if (r > 32767)  begin r = 32767;  m_sat++; end
      if (r < -32768) begin r = -32768; m_sat++; end
      exp_q.push_back(int'(r));
    end
    ph = ~ph;
  endfunction

  // Compare process: samples DUT away from the active edge, advances the model.
  always @(negedge clk) begin
    if (reset) begin
      model_clear();
      for (int i = 0; i < 7; i++) m_coef[i] = 0;
      m_coef[7] = 16384;
    end else begin
      chk("in_ready_rule", in_ready, (!out_valid || out_ready) ? 1 : 0);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (flush) begin
        model_clear();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_out", out_data, 99999);
          else chk("stream_out", out_data, exp_q.pop_front());
          got.push_back(int'(out_data));
        end
        if (in_valid && in_ready) model_accept(int'(in_data));
        prev_stall = out_valid && !out_ready;
        prev_data  = int'(out_data);
      end
      if (coef_wr_en) m_coef[coef_wr_addr] = int'(coef_wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(int a, int d);
    coef_wr_en = 1'b1;
    coef_wr_addr = 3'(a);
    coef_wr_data = 16'(d);
    tick();
    coef_wr_en = 1'b0;
  endtask

  task automatic feed(int x, int n);
    in_valid = 1'b1;
    in_data = 16'(x);
    for (int i = 0; i < n; i++) tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(string name);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk(name, exp_q.size(), 0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    got.delete();
  endtask

  function automatic void chk_got(string name, int idx, int exp);
    if (idx < got.size()) chk(name, got[idx], exp);
    else chk({name, "_missing"}, got.size(), idx + 1);
  endfunction

  int wv [7] = '{459, -484, 749, -1154, 1834, -3323, 10377};
  int t3 [15] = '{230, -242, 375, -577, 917, -1661, 5189, 5189, -1661, 917, -577, 375, -242, 230, 0};

  task automatic test1(string tag);
    got.delete();
    in_data = 16'sd1000;
    in_valid = 1'b1;
    tick();
    tick();
    chk({tag, "_lat_e2"}, out_valid, 0);
    tick();
    chk({tag, "_lat_e3"}, out_valid, 0);
    tick();
    chk({tag, "_lat_e4"}, out_valid, 1);
    for (int i = 0; i < 30; i++) tick();
    in_valid = 1'b0;
    drain({tag, "_drain"});
    chk_got({tag, "_out0"}, 0, 0);
    chk_got({tag, "_out5"}, 5, 0);
    chk_got({tag, "_out6"}, 6, 500);
    chk_got({tag, "_outlast"}, got.size() - 1, 500);
  endtask

  initial begin
    // Reset defaults
    #12;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Test 1: default coefficients pass x/2
    test1("t1");

    // Test 5: backpressure with a varied stream
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = 16'(i * 731 - 9000);
      if (i == 12) out_ready = 1'b0;
      if (i == 22) out_ready = 1'b1;
      if (i >= 16 && i < 22) chk("stall_in_ready", in_ready, 0);
      tick();
    end
    drain("t5_drain");

    // Test 2: impulse on the even phase
    do_flush();
    for (int i = 0; i < 7; i++) wr_coef(i, wv[i]);
    wr_coef(7, 16383);
    got.delete();
    feed(16384, 1);
    feed(0, 30);
    drain("t2_drain");
    for (int i = 0; i < 6; i++) chk_got("t2_zero", i, 0);
    chk_got("t2_centre", 6, 8192);
    chk_got("t2_after", 7, 0);

    // Test 3: impulse on the odd phase
    do_flush();
    feed(0, 1);
    feed(16384, 1);
    feed(0, 30);
    drain("t3_drain");
    for (int i = 0; i < 15; i++) chk_got("t3_resp", i, t3[i]);

    // Test 6: flush mid-stream wins over in_valid; coefficients retained
    feed(1000, 9);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 16'sd7777;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    got.delete();
    feed(1000, 40);
    drain("t6_drain");
    chk_got("t6_first", 0, 14);
    chk_got("t6_dc", got.size() - 1, 1016);

    // Test 4: saturation both ways
    do_flush();
    for (int i = 0; i < 8; i++) wr_coef(i, 16383);
    feed(32767, 30);
    drain("t4p_drain");
    chk_got("t4_pos", got.size() - 1, 32767);
    got.delete();
    feed(-32768, 30);
    drain("t4n_drain");
    chk_got("t4_neg", got.size() - 1, -32768);
`ifdef HB_SAT_CNT_EN
    chk("t4_sat_count", sat_count, m_sat);
`endif

    // Async reset mid-stream
    in_valid = 1'b1;
    in_data = 16'sd1000;
    for (int i = 0; i < 20; i++) tick();
    chk("pre_reset_data_nz", (out_data != 0) ? 1 : 0, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_data", out_data, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 1);
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    test1("t1r");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
